// File: rtl/mem_field_rmw.sv
// Field read-modify-write front end: turns mem[addr][base +: len] <= data into read, merge, masked full-word write.
// Latency: write (mem_wen/wr_done) 2 cycles after accept; one request per cycle sustained.
// Backpressure: req_ready=1 whenever out of reset; with MEM_RMW_HAZARD_STALL_EN defined, held low while req_addr hits a B/W/L entry.
//
// Optional build macro: MEM_RMW_HAZARD_STALL_EN
//   undefined : same-address hazards resolved by forwarding from the W and L registers
//   defined   : forwarding removed, conflicting requests stalled at req_ready instead
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/base/len/data        field write request (len 0 = no-op, len > FIELD_W clamped)
//   mem_ren/mem_raddr/mem_rdata   memory read port, rdata valid the cycle after ren
//   mem_wen/mem_waddr/mem_wdata/mem_wmask   memory write port (bit mask of field bits)
//   wr_done                       pulse coincident with mem_wen

module mem_field_rmw #(
    parameter  int ADDR_W  = 4,
    parameter  int DATA_W  = 8,
    parameter  int FIELD_W = 4,
    localparam int BASE_W  = $clog2(DATA_W),
    localparam int LEN_W   = $clog2(FIELD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BASE_W-1:0] req_base,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [FIELD_W-1:0] req_data,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    output logic              wr_done
);

    // Wide enough that a field shifted by any base never wraps; the top bits are simply dropped.
    localparam int WIDE_W = DATA_W + FIELD_W;

    logic               rdy_q;
    logic               hazard;
    logic               accept;
    logic [ADDR_W-1:0]  raddr_q;

    // Stage B: request waiting for its read data
    logic               b_vld;
    logic [ADDR_W-1:0]  b_addr;
    logic [BASE_W-1:0]  b_base;
    logic [LEN_W-1:0]   b_len;
    logic [FIELD_W-1:0] b_data;

    // Stage W: word being written this cycle
    logic               w_vld;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic [DATA_W-1:0]  w_mask;

    // L: word written in the previous cycle (memory read-during-write returns old data)
    logic               l_vld;
    logic [ADDR_W-1:0]  l_addr;
    logic [DATA_W-1:0]  l_data;

    logic [LEN_W-1:0]   len_c;
    logic [FIELD_W-1:0] ones;
    logic [WIDE_W-1:0]  wide_mask;
    logic [WIDE_W-1:0]  wide_dat;
    logic [DATA_W-1:0]  fmask;
    logic [DATA_W-1:0]  fdat;
    logic [DATA_W-1:0]  old_word;
    logic [DATA_W-1:0]  merged;
    logic               do_write;

`ifdef MEM_RMW_HAZARD_STALL_EN
    assign hazard = (b_vld && (b_addr == req_addr)) ||
                    (w_vld && (w_addr == req_addr)) ||
                    (l_vld && (l_addr == req_addr));
`else
    assign hazard = 1'b0;
`endif

    assign req_ready = rdy_q & ~hazard;
    assign accept    = req_valid & req_ready;
    assign mem_ren   = accept;
    // Read address follows the accepted request, otherwise holds the last issued one.
    assign mem_raddr = accept ? req_addr : raddr_q;

    // ---------------- merge (stage B) ----------------
    assign len_c = (b_len > LEN_W'(FIELD_W)) ? LEN_W'(FIELD_W) : b_len;

    always_comb begin
        ones = '0;
        for (int i = 0; i < FIELD_W; i++) begin
            ones[i] = (i < int'(len_c));
        end
    end

    assign wide_mask = WIDE_W'(ones) << b_base;
    assign wide_dat  = WIDE_W'(b_data & ones) << b_base;
    assign fmask     = wide_mask[DATA_W-1:0];
    assign fdat      = wide_dat[DATA_W-1:0];

`ifdef MEM_RMW_HAZARD_STALL_EN
    assign old_word = mem_rdata;
`else
    // W is newest (not yet in memory); L was written while our read was in flight.
    always_comb begin
        if (w_vld && (w_addr == b_addr)) begin
            old_word = w_data;
        end else if (l_vld && (l_addr == b_addr)) begin
            old_word = l_data;
        end else begin
            old_word = mem_rdata;
        end
    end
`endif

    assign merged   = (old_word & ~fmask) | (fdat & fmask);
    // Empty mask means nothing to write: W and L stay untouched.
    assign do_write = b_vld & (|fmask);

    // ---------------- sequential ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            raddr_q <= '0;
            b_vld   <= 1'b0;
            b_addr  <= '0;
            b_base  <= '0;
            b_len   <= '0;
            b_data  <= '0;
            w_vld   <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            w_mask  <= '0;
            l_vld   <= 1'b0;
            l_addr  <= '0;
            l_data  <= '0;
        end else begin
            rdy_q <= 1'b1;
            b_vld <= accept;
            if (accept) begin
                raddr_q <= req_addr;
                b_addr  <= req_addr;
                b_base  <= req_base;
                b_len   <= req_len;
                b_data  <= req_data;
            end
            w_vld <= do_write;
            if (do_write) begin
                w_addr <= b_addr;
                w_data <= merged;
                w_mask <= fmask;
            end
            l_vld <= w_vld;
            if (w_vld) begin
                l_addr <= w_addr;
                l_data <= w_data;
            end
        end
    end

    assign mem_wen   = w_vld;
    assign wr_done   = w_vld;
    assign mem_waddr = w_addr;
    assign mem_wdata = w_data;
    assign mem_wmask = w_mask;

endmodule

// File: tb/tb_mem_field_rmw.sv
module tb_mem_field_rmw;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic [2:0] req_base;
    logic [2:0] req_len;
    logic [3:0] req_data;
    logic       mem_ren;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_wmask;
    logic       wr_done;

    // bench-side memory with 1-cycle sync read, old data on read-during-write
    logic [7:0] mem [16];
    logic       pre_en;
    logic [3:0] pre_addr;
    logic [7:0] pre_dat;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_field_rmw dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_base  (req_base),
        .req_len   (req_len),
        .req_data  (req_data),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .wr_done   (wr_done)
    );

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
        if (mem_wen) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        if (pre_en)  mem[pre_addr] <= pre_dat;
    end

    typedef struct {
        logic [3:0] addr;
        logic [2:0] base;
        logic [2:0] len;
        logic [3:0] data;
        logic [7:0] init;
        logic       exp_wen;
        logic [7:0] exp_wdata;
        logic [7:0] exp_wmask;
        logic [7:0] exp_final;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] a, input logic [2:0] b, input logic [2:0] l, input logic [3:0] d);
        req_valid = 1'b1; req_addr = a; req_base = b; req_len = l; req_data = d;
    endtask

    initial begin
        vecs[0] = '{4'd3,  3'd2, 3'd4, 4'hF, 8'hA5, 1'b1, 8'hBD, 8'h3C, 8'hBD};
        vecs[1] = '{4'd1,  3'd6, 3'd4, 4'hA, 8'h00, 1'b1, 8'h80, 8'hC0, 8'h80};
        vecs[2] = '{4'd2,  3'd0, 3'd0, 4'hF, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{4'd2,  3'd0, 3'd7, 4'hF, 8'h00, 1'b1, 8'h0F, 8'h0F, 8'h0F};
        vecs[4] = '{4'd4,  3'd3, 3'd1, 4'h0, 8'hFF, 1'b1, 8'hF7, 8'h08, 8'hF7};
        vecs[5] = '{4'd9,  3'd1, 3'd3, 4'hD, 8'h00, 1'b1, 8'h0A, 8'h0E, 8'h0A};
        vecs[6] = '{4'd15, 3'd5, 3'd4, 4'h6, 8'h81, 1'b1, 8'hC1, 8'hE0, 8'hC1};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_base = '0; req_len = '0; req_data = '0;
        pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_ren",   mem_ren,   0);
        chk("rst_wen",   mem_wen,   0);
        chk("rst_done",  wr_done,   0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wmask", mem_wmask, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        // single-request vectors
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].addr, vecs[i].init);
            drive(vecs[i].addr, vecs[i].base, vecs[i].len, vecs[i].data);
            #1;
            chk($sformatf("v%0d_ren", i),   mem_ren,   1);
            chk($sformatf("v%0d_raddr", i), mem_raddr, vecs[i].addr);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_wen_early", i), mem_wen, 0);
            @(negedge clk);
            chk($sformatf("v%0d_wen", i),  mem_wen, vecs[i].exp_wen);
            chk($sformatf("v%0d_done", i), wr_done, vecs[i].exp_wen);
            if (vecs[i].exp_wen) begin
                chk($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].addr);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_wmask", i), mem_wmask, vecs[i].exp_wmask);
            end
            @(negedge clk);
            chk($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_final);
        end

        // idle: enables low, addresses hold their last value
        chk("idle_ren",   mem_ren,   0);
        chk("idle_wen",   mem_wen,   0);
        chk("idle_raddr", mem_raddr, 15);
        chk("idle_waddr", mem_waddr, 15);

        // back-to-back same address: forwarding from W
        preload(4'd5, 8'h00);
        drive(4'd5, 3'd0, 3'd4, 4'hF);
        @(negedge clk);
        drive(4'd5, 3'd4, 3'd4, 4'hA);
        #1;
        chk("b2b_ready", req_ready, 1);
        chk("b2b_ren",   mem_ren,   1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_wen1",   mem_wen,   1);
        chk("b2b_wdata1", mem_wdata, 8'h0F);
        @(negedge clk);
        chk("b2b_wen2",   mem_wen,   1);
        chk("b2b_wdata2", mem_wdata, 8'hAF);
        chk("b2b_wmask2", mem_wmask, 8'hF0);
        @(negedge clk);
        chk("b2b_wen_off", mem_wen, 0);
        chk("b2b_mem",     mem[5],  8'hAF);

        // one idle cycle between same-address requests: forwarding from L
        preload(4'd7, 8'h00);
        drive(4'd7, 3'd0, 3'd2, 4'h3);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        drive(4'd7, 3'd2, 3'd2, 4'h3);
        chk("lfw_wdata1", mem_wdata, 8'h03);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("lfw_wen2",   mem_wen,   1);
        chk("lfw_wdata2", mem_wdata, 8'h0F);
        chk("lfw_wmask2", mem_wmask, 8'h0C);
        @(negedge clk);
        chk("lfw_mem", mem[7], 8'h0F);

        // reset while a request is in flight
        drive(4'd3, 3'd0, 3'd4, 4'h5);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", req_ready, 0);
        chk("mrst_wen",   mem_wen,   0);
        chk("mrst_waddr", mem_waddr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_wmask", mem_wmask, 0);
        @(negedge clk);
        chk("mrst_wen_b", mem_wen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ready_rel", req_ready, 1);
        chk("mrst_wen_c",     mem_wen,   0);
        chk("mrst_mem",       mem[3],    8'hBD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
